sd_rx_dma_fifo: RTL
===================

SD_RX_DMA_FIFO -- requirements
Module: sd_rx_dma_fifo

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, setting FIFO storage to 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have port i_clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_fifo_flush  input  1  one-cycle discard of all stored and staged data.
REQ-005 SHALL have port i_fifo_push  input  1  write i_fifo_data into FIFO.
REQ-006 SHALL have port i_fifo_data  input  32  word to store.
REQ-007 SHALL have port o_fifo_full  output  1  storage holds 2**DEPTH_LOG2 words.
REQ-008 SHALL have port o_fifo_empty  output  1  storage holds 0 words.
REQ-009 SHALL have port o_fifo_count  output  DEPTH_LOG2+1  words in storage, excluding the staged word.
REQ-010 SHALL have port o_overflow  output  1  sticky: push attempted while full.
REQ-011 SHALL have port o_request  output  1  staged word awaiting bus acceptance.
REQ-012 SHALL have port o_write  output  1  bus direction; constant 1.
REQ-013 SHALL have port i_busy  input  1  bus stall; transfer accepted in any cycle with o_request=1 and i_busy=0.
REQ-014 SHALL have port o_data  output  32  staged word.

Function
REQ-015 SHALL implement circular storage with DEPTH_LOG2-bit read/write pointers wrapping modulo 2**DEPTH_LOG2.
REQ-016 SHALL store i_fifo_data on push when not full; count +1, write pointer +1 at next edge.
REQ-017 SHALL drop a push while full (storage, pointers, count unchanged) and set o_overflow at next edge.
REQ-018 SHALL keep count unchanged on simultaneous accepted push and pop, including when full (pop frees slot same cycle, push accepted).
REQ-019 SHALL derive o_fifo_full/o_fifo_empty from registered count: full = count==2**DEPTH_LOG2, empty = count==0.
REQ-020 SHALL run FSM states IDLE and REQ; o_request = (state==REQ), registered.
REQ-021 IDLE: if count!=0, load o_data from head, pop, go REQ; else stay.
REQ-022 REQ: hold o_data and o_request stable while i_busy=1.
REQ-023 REQ with i_busy=0: if count!=0, load next head into o_data, pop, stay REQ (back-to-back, one word per cycle); else go IDLE.
REQ-024 SHALL give latency push at edge N into empty FIFO in IDLE -> o_fifo_empty=0 after N, o_request=1 after N+1.
REQ-025 Flush: pointers, count, o_overflow cleared; state IDLE; o_request=0 after next edge.
REQ-026 Flush with simultaneous push: flush wins; word discarded.
REQ-027 Flush in cycle with o_request=1, i_busy=0: that transfer counts as accepted (upstream address advance valid); nothing further requested.
REQ-028 o_overflow SHALL clear only on flush or reset.

Reset
REQ-029 On i_reset: state IDLE, pointers 0, count 0, o_request=0, o_overflow=0, o_fifo_empty=1, o_fifo_full=0, o_data=0; o_write=1 at all times.
REQ-030 Reset mid-transfer SHALL abandon staged and stored words; no request after reset until new push.
REQ-031 i_reset SHALL take priority over flush, push and bus acceptance.

Verification
REQ-032 Single push 0xDEADBEEF, i_busy=0 -> o_request high exactly one cycle at N+2, o_data=0xDEADBEEF, count back to 0.
REQ-033 Push 8 words 0..7 with i_busy=1 (DEPTH_LOG2=3) -> word 0 staged, count=7; push 2 more -> count=8, full=1, 2nd extra dropped, o_overflow=1; release i_busy -> 9 transfers, order 0..8, one per cycle.
REQ-034 Full FIFO, simultaneous push 0xA5A5A5A5 and accepted transfer -> count stays 8, full stays 1, o_overflow stays 0, 0xA5A5A5A5 delivered last.
REQ-035 Flush while o_request=1, i_busy=1, count=4 -> o_request=0, count=0, empty=1, o_overflow=0 next cycle; no further request.
REQ-036 Pointer wrap: stream 20 words 1..20 with random i_busy -> delivered in order, no loss, no duplication.
REQ-037 Assert i_reset with count=5 and o_request=1 -> all outputs at reset values next cycle; o_write stays 1.

Source files
------------

// File: rtl/sd_rx_dma_fifo.sv
// sd_rx_dma_fifo: receive-side word FIFO feeding a DMA bus master.
// Words pushed from the card side are held in circular storage. One word at a
// time is staged into o_data and offered to the bus with o_request. The next
// head is restaged in the same cycle a transfer is accepted, so an unstalled
// bus can drain one word per cycle.
module sd_rx_dma_fifo #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_fifo_flush,
  input  logic                  i_fifo_push,
  input  logic [31:0]           i_fifo_data,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic [DEPTH_LOG2:0]   o_fifo_count,
  output logic                  o_overflow,
  output logic                  o_request,
  output logic                  o_write,
  input  logic                  i_busy,
  output logic [31:0]           o_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [31:0]             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_count;
  logic                    r_overflow;
  logic [31:0]             r_data;
  logic                    w_pop;
  logic                    w_push_ok;
  logic                    w_nonempty;
  logic                    w_full;

  assign w_nonempty   = (r_count != '0);
  assign w_full       = (r_count == FULL_CNT);
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is still accepted then.
  assign w_push_ok    = i_fifo_push && (!w_full || w_pop);

  assign o_fifo_full  = w_full;
  assign o_fifo_empty = !w_nonempty;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;
  assign o_request    = (r_state == REQ);
  assign o_write      = 1'b1;
  assign o_data       = r_data;

  // Next-state and pop decision; flush abandons any staged word.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    if (i_fifo_flush) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_nonempty) begin
            w_pop        = 1'b1;
            w_state_next = REQ;
          end
        end
        REQ: begin
          if (!i_busy) begin
            if (w_nonempty) begin
              w_pop = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Storage array; written only on an accepted push outside reset and flush.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_fifo_flush && w_push_ok) begin
      r_mem[r_wptr] <= i_fifo_data;
    end
  end

  // Pointers, occupancy, overflow flag and the staged output word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_data     <= '0;
    end else if (i_fifo_flush) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_fifo_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule
